tpu_operand_feeder: RTL and testbench
=====================================

Name: tpu_operand_feeder

Overview:
Upstream sequencer for the 2x2 systolic TPU core. Software loads a 2x2 operand matrix into staging registers over APB and writes GO. The block then pushes the operand vectors into the core's two input FIFOs, holds the core's start high until done, and reports completion and errors through an APB status register.

Parameters:
BASE_ADDR, 32'h100, APB base address of the register window.
NUM_VEC, 2, operand vectors pushed per run; each vector is one in1/in2 pair; range 1..4.
TIMEOUT, 64, max cycles o_start stays high without i_done before an error is raised.

Ports:
i_clk  input  1  clock
i_rstn  input  1  async active-low reset
i_paddr  input  32  APB address
i_psel  input  1  APB select
i_penable  input  1  APB enable
i_pwrite  input  1  APB write
i_pwdata  input  32  APB write data
o_prdata  output  32  APB read data
o_pready  output  1  APB ready; tied 1
o_in1  output  32  data to core input FIFO 0
o_in2  output  32  data to core input FIFO 1
o_in1_en  output  1  write strobe, FIFO 0
o_in2_en  output  1  write strobe, FIFO 1
o_start  output  1  run request to core
i_full  input  2  core input FIFO full flags [1:0]
i_done  input  1  core done flag
o_busy  output  1  high in any state other than IDLE
o_irq  output  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset: i_rstn, asynchronous, active-low; clock i_clk. All outputs 0. All staging registers 0. FSM in IDLE. STATUS cleared.
- Register map (offsets from BASE_ADDR):
  - 0x00 CTRL (W): bit0 GO, self-clearing pulse. bit1 CLR_STATUS, clears DONE and ERR. bit2 IRQ_EN, stored.
  - 0x04 STATUS (R): bit0 BUSY, bit1 DONE (sticky), bit2 ERR (sticky). bit3 CTRL.IRQ_EN readback.
  - 0x10+8k: OPA[k][0]. 0x14+8k: OPA[k][1]. k = 0..NUM_VEC-1.
- APB:
  - Write accepted when psel&penable&pwrite, captured on the clock edge.
  - Read data is combinational when psel&penable&!pwrite, otherwise 0.
  - Unmapped reads return 0. Unmapped writes are ignored.
  - Writes to OPA registers while BUSY are ignored.
- FSM:
  - IDLE: GO -> PUSH with idx=0. GO while busy is ignored.
  - PUSH: if i_full==2'b00, drive o_in1=OPA[idx][0] and o_in2=OPA[idx][1], assert o_in1_en and o_in2_en together for one cycle, then idx++. Both strobes always fire in the same cycle. If either full bit is set, stall with no strobe. After idx reaches NUM_VEC-1 and that vector is pushed -> RUN next cycle.
  - RUN: o_start=1 and the timeout counter counts. i_done=1 -> DONE_ST. Counter reaches TIMEOUT-1 without i_done -> set ERR, -> IDLE.
  - DONE_ST: o_start=0 and DONE set for one cycle, then -> IDLE.
  - o_start is registered, high exactly during RUN. o_start drops the cycle after i_done is sampled.
- Latency: GO write to first o_in*_en is 1 cycle, assuming not full. Strobes on consecutive cycles when never full. o_start rises the cycle after the last strobe.
- Simultaneous CLR_STATUS and a DONE/ERR set event in the same cycle: the set wins.
- Reset asserted mid-run drops o_start and the strobes immediately (asynchronous). The core must see start low.
- o_in1/o_in2 are 0 whenever their strobes are low.

Optional Feature:
- Macro: TPU_FEEDER_IRQ_EN.
- Defined: o_irq = IRQ_EN & (DONE | ERR). Registered, level-held until CLR_STATUS.
- Undefined: o_irq tied 0. The IRQ_EN bit reads back 0 and writes to it are ignored. The port stays in the port list.

Test Plan:
- Basic run: load OPA = {1,2,3,4} (NUM_VEC=2), i_full=0, write GO, model i_done 4 cycles after o_start rises -> strobes carry (1,2) then (3,4) on consecutive cycles; o_start high exactly 5 cycles; STATUS reads 0x2.
- Backpressure: hold i_full=2'b01 for 3 cycles after GO -> no strobes during those cycles; the (1,2) push occurs on the first cycle with i_full==0; order unchanged.
- Timeout: GO with i_done never asserted -> o_start high for 64 cycles, then low; STATUS=0x4; with the macro defined and IRQ_EN=1, o_irq=1.
- Busy protection: write OPA[0][0]=0xAA and GO while in RUN -> the push order of the active run is unaffected and no second run starts; OPA[0][0] reads back its old value.
- Status clear race: write CLR_STATUS on the same cycle DONE_ST is entered -> DONE reads 1 afterwards; a second CLR_STATUS clears it to 0.
- Reset mid-run: deassert i_rstn during RUN -> o_start, o_busy and o_irq go 0 immediately; STATUS reads 0 after reset release.

Source files
------------

// File: rtl/tpu_operand_feeder.sv
// APB-loaded operand sequencer feeding the 2x2 systolic core's input FIFOs.
// Optional completion interrupt is built in when TPU_FEEDER_IRQ_EN is defined.
module tpu_operand_feeder #(
  parameter logic [31:0] BASE_ADDR = 32'h100,
  parameter int          NUM_VEC   = 2,
  parameter int          TIMEOUT   = 64
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_paddr,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic [31:0] o_in1,
  output logic [31:0] o_in2,
  output logic        o_in1_en,
  output logic        o_in2_en,
  output logic        o_start,
  input  logic [1:0]  i_full,
  input  logic        i_done,
  output logic        o_busy,
  output logic        o_irq
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [2:0]        LP_NV   = 3'(NUM_VEC);
  localparam logic [CNT_W-1:0]  LP_TMAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_RUN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_opa0 [4];
  logic [31:0]       r_opa1 [4];
  logic [2:0]        r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_en;
  logic [31:0]       r_in1, r_in2;
  logic              r_start;
  logic              r_done, r_err;

  logic              w_acc, w_wr, w_rd;
  logic [31:0]       w_off, w_opa_off;
  logic              w_opa_hit, w_j, w_opa_wr;
  logic [1:0]        w_k;
  logic              w_ctrl_wr, w_go, w_clr;
  logic              w_push, w_done_set, w_err_set;
  logic              w_done_nxt, w_err_nxt;
  logic              w_ien;
  logic [31:0]       w_status;

  assign w_acc     = i_psel & i_penable;
  assign w_wr      = w_acc & i_pwrite;
  assign w_rd      = w_acc & ~i_pwrite;
  assign w_off     = i_paddr - BASE_ADDR;
  assign w_opa_off = w_off - 32'h10;
  assign w_opa_hit = (w_off >= 32'h10) && (w_opa_off < 32'(8 * NUM_VEC)) &&
                     (w_off[1:0] == 2'b00);
  assign w_k       = w_opa_off[4:3];
  assign w_j       = w_opa_off[2];
  assign w_ctrl_wr = w_wr && (w_off == 32'h0);
  assign w_go      = w_ctrl_wr & i_pwdata[0];
  assign w_clr     = w_ctrl_wr & i_pwdata[1];
  // Staging registers are frozen for the whole run, including DONE_ST.
  assign w_opa_wr  = w_wr & w_opa_hit & (r_state == S_IDLE);

  // A set event in the same cycle as CLR_STATUS wins over the clear.
  assign w_done_nxt = w_done_set | (r_done & ~w_clr);
  assign w_err_nxt  = w_err_set  | (r_err  & ~w_clr);

  always_comb begin
    w_next     = r_state;
    w_push     = 1'b0;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) w_next = S_PUSH;
      S_PUSH: begin
        if (r_idx == LP_NV) w_next = S_RUN;
        else if (i_full == 2'b00) w_push = 1'b1;
      end
      S_RUN: begin
        if (i_done) begin
          w_next = S_DONE;
        end else if (r_cnt == LP_TMAX) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_DONE: begin
        w_done_set = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_idx <= '0;
      else if (w_push) r_idx <= r_idx + 3'd1;
      r_cnt   <= (r_state == S_RUN) ? r_cnt + 1'b1 : '0;
      r_en    <= w_push;
      r_in1   <= w_push ? r_opa0[r_idx[1:0]] : '0;
      r_in2   <= w_push ? r_opa1[r_idx[1:0]] : '0;
      r_start <= (w_next == S_RUN);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 4; i++) begin
        r_opa0[i] <= '0;
        r_opa1[i] <= '0;
      end
    end else if (w_opa_wr) begin
      if (w_j) r_opa1[w_k] <= i_pwdata;
      else     r_opa0[w_k] <= i_pwdata;
    end
  end

`ifdef TPU_FEEDER_IRQ_EN
  logic r_irq_en, r_irq;
  logic w_ien_nxt;
  assign w_ien_nxt = w_ctrl_wr ? i_pwdata[2] : r_irq_en;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_ien_nxt;
      r_irq    <= w_ien_nxt & (w_done_nxt | w_err_nxt);
    end
  end
  assign w_ien = r_irq_en;
  assign o_irq = r_irq;
`else
  assign w_ien = 1'b0;
  assign o_irq = 1'b0;
`endif

  assign w_status = {28'd0, w_ien, r_err, r_done, o_busy};

  always_comb begin
    o_prdata = '0;
    if (w_rd) begin
      if (w_off == 32'h4) o_prdata = w_status;
      else if (w_opa_hit) o_prdata = w_j ? r_opa1[w_k] : r_opa0[w_k];
    end
  end

  assign o_pready = 1'b1;
  assign o_busy   = (r_state != S_IDLE);
  assign o_start  = r_start;
  assign o_in1_en = r_en;
  assign o_in2_en = r_en;
  assign o_in1    = r_in1;
  assign o_in2    = r_in2;

endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Randomized self-checking bench for tpu_operand_feeder against a
// transaction-level model of push order, push timing, run length and status.
module tb_tpu_operand_feeder;
  localparam logic [31:0] BASE  = 32'h100;
  localparam int          NV    = 2;
  localparam int          TMO   = 64;
  localparam int          NEVER = 1000;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [31:0] i_paddr;
  logic        i_psel, i_penable, i_pwrite;
  logic [31:0] i_pwdata;
  logic [31:0] o_prdata;
  logic        o_pready;
  logic [31:0] o_in1, o_in2;
  logic        o_in1_en, o_in2_en, o_start;
  logic [1:0]  i_full;
  logic        i_done;
  logic        o_busy, o_irq;

  always #5 i_clk = ~i_clk;

  tpu_operand_feeder #(.BASE_ADDR(BASE), .NUM_VEC(NV), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_paddr(i_paddr), .i_psel(i_psel),
    .i_penable(i_penable), .i_pwrite(i_pwrite), .i_pwdata(i_pwdata),
    .o_prdata(o_prdata), .o_pready(o_pready), .o_in1(o_in1), .o_in2(o_in2),
    .o_in1_en(o_in1_en), .o_in2_en(o_in2_en), .o_start(o_start),
    .i_full(i_full), .i_done(i_done), .o_busy(o_busy), .o_irq(o_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } push_t;

  push_t       exp_q[$];
  push_t       e;
  int          cyc = 0;
  int          hi_cnt = 0;
  int          last_strobe = 0;
  logic        prev_start = 1'b0;
  logic [1:0]  last_full = 2'b00;
  logic [31:0] opa [NV][2];
  logic [1:0]  pat [64];

  // Observe outputs mid-cycle: push contents/order/timing and o_start length.
  always @(negedge i_clk) begin
    cyc++;
    if (i_rstn) begin
      if (o_in1_en !== o_in2_en) chk("strobe_pair", 32'(o_in2_en), 32'(o_in1_en));
      if (o_in1_en) begin
        chk("stall_full", 32'(last_full), 32'd0);
        if (exp_q.size() == 0) begin
          chk("extra_push", 32'(o_in1_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("in1", o_in1, e.a);
          chk("in2", o_in2, e.b);
          chk("push_cyc", 32'(cyc), 32'(e.cyc));
        end
        last_strobe = cyc;
      end else begin
        chk("idle_data", o_in1 | o_in2, 32'd0);
      end
      if (o_start) begin
        if (!prev_start) chk("start_rise", 32'(cyc), 32'(last_strobe + 1));
        hi_cnt++;
      end
    end
    prev_start = o_start;
    last_full  = i_full;
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    i_paddr = a; i_pwdata = d; i_pwrite = 1'b1; i_psel = 1'b1; i_penable = 1'b0;
    @(posedge i_clk); #1 i_penable = 1'b1;
    @(posedge i_clk); #1 i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    i_paddr = a; i_pwrite = 1'b0; i_psel = 1'b1; i_penable = 1'b0;
    @(posedge i_clk); #1 i_penable = 1'b1;
    @(negedge i_clk); d = o_prdata;
    @(posedge i_clk); #1 i_psel = 1'b0; i_penable = 1'b0;
  endtask

  function automatic logic ien_eff(input logic ien);
`ifdef TPU_FEEDER_IRQ_EN
    return ien;
`else
    return 1'b0;
`endif
  endfunction

  // mode: 0 plain, 1 busy protection, 2 clear/set race, 3 reset during RUN
  task automatic run(input bit rnd, input int d, input int nf, input logic ien, input int mode);
    int          cyc0, pushes, exp_hi, k, clr_left, v, j;
    bit          done_exp;
    logic [31:0] rd, exp_st;

    for (int vv = 0; vv < NV; vv++)
      for (int jj = 0; jj < 2; jj++) begin
        opa[vv][jj] = rnd ? $urandom : 32'(2 * vv + jj + 1);
        apb_write(BASE + 32'(16 + 8 * vv + 4 * jj), opa[vv][jj]);
      end
    v = $urandom_range(0, NV - 1);
    j = $urandom_range(0, 1);
    apb_read(BASE + 32'(16 + 8 * v + 4 * j), rd);
    chk("opa_readback", rd, opa[v][j]);
    if (mode != 3) apb_write(BASE, {29'd0, ien, 2'b10});

    for (int i = 0; i < 64; i++)
      pat[i] = (i < nf) ? 2'b01 :
               (rnd && i < 40 && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    hi_cnt = 0;
    apb_write(BASE, {29'd0, ien, 2'b01});
    cyc0 = cyc;
    pushes = 0;
    for (int i = 0; i < 64; i++)
      if (pat[i] == 2'b00 && pushes < NV) begin
        exp_q.push_back('{opa[pushes][0], opa[pushes][1], cyc0 + i + 2});
        pushes++;
      end

    done_exp = (d < TMO);
    exp_hi   = done_exp ? d + 1 : TMO;
    clr_left = 0;
    for (k = 0; k < 400; k++) begin
      i_full = (k < 64) ? pat[k] : 2'($urandom_range(0, 3));
      i_done = o_start && (hi_cnt == d);
      if (mode == 2) begin
        if (i_done) clr_left = 2;
        if (clr_left > 0) begin
          i_paddr = BASE; i_pwdata = {29'd0, ien, 2'b10};
          i_pwrite = 1'b1; i_psel = 1'b1; i_penable = 1'b1;
          clr_left--;
        end else begin
          i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
        end
      end
      if (mode == 3 && hi_cnt == 5) begin
        chk("irq_before_rst", 32'(o_irq), 32'(ien_eff(ien)));
        i_rstn = 1'b0;
        #1;
        chk("rst_start", 32'(o_start), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_irq", 32'(o_irq), 32'd0);
        chk("rst_strobe", 32'(o_in1_en), 32'd0);
        break;
      end
      if (mode == 1 && o_start && hi_cnt == 1) begin
        apb_write(BASE + 32'h10, 32'hAA);
        apb_write(BASE, {29'd0, ien, 2'b01});
      end
      if (!o_busy) break;
      @(posedge i_clk); #1;
    end
    i_full = 2'b00;
    i_done = 1'b0;

    if (mode == 3) begin
      exp_q.delete();
      @(negedge i_clk); i_rstn = 1'b1;
      @(posedge i_clk); #1;
      apb_read(BASE + 32'h4, rd);
      chk("status_after_rst", rd, 32'd0);
      apb_read(BASE + 32'h10, rd);
      chk("opa_after_rst", rd, 32'd0);
      return;
    end

    chk("run_end", 32'(o_busy), 32'd0);
    chk("pushes_left", 32'(exp_q.size()), 32'd0);
    chk("start_cycles", 32'(hi_cnt), 32'(exp_hi));
    exp_st = (done_exp ? 32'h2 : 32'h4) | (32'(ien_eff(ien)) << 3);
    apb_read(BASE + 32'h4, rd);
    chk("status", rd, exp_st);
    chk("irq", 32'(o_irq), 32'(ien_eff(ien)));

    if (mode == 1) begin
      apb_read(BASE + 32'h10, rd);
      chk("opa_protected", rd, opa[0][0]);
      repeat (5) @(posedge i_clk);
      #1;
      chk("no_second_run", 32'(o_busy), 32'd0);
    end
    if (mode == 2) begin
      apb_write(BASE, {29'd0, ien, 2'b10});
      apb_read(BASE + 32'h4, rd);
      chk("status_cleared", rd, 32'(ien_eff(ien)) << 3);
      chk("irq_cleared", 32'(o_irq), 32'd0);
    end
  endtask

  logic [31:0] rd0;

  initial begin
    i_rstn = 1'b0; i_paddr = '0; i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    i_pwdata = '0; i_full = 2'b00; i_done = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_start", 32'(o_start), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_strobe", 32'(o_in1_en), 32'd0);
    chk("reset_irq", 32'(o_irq), 32'd0);
    chk("reset_prdata", o_prdata, 32'd0);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    apb_read(BASE + 32'h4, rd0);
    chk("reset_status", rd0, 32'd0);
    apb_read(BASE + 32'h14, rd0);
    chk("reset_opa", rd0, 32'd0);
    apb_read(BASE + 32'h8, rd0);
    chk("unmapped_8", rd0, 32'd0);
    apb_read(BASE + 32'(16 + 8 * NV), rd0);
    chk("unmapped_top", rd0, 32'd0);

    run(1'b0, 4, 0, 1'b0, 0);       // basic run
    run(1'b0, 4, 3, 1'b0, 0);       // backpressure on FIFO 0
    run(1'b0, NEVER, 0, 1'b1, 0);   // timeout with IRQ_EN
    run(1'b0, NEVER, 0, 1'b1, 3);   // reset during RUN
    run(1'b0, 10, 0, 1'b0, 1);      // writes while busy
    run(1'b0, 3, 0, 1'b1, 2);       // clear/set race
    for (int n = 0; n < 6; n++)
      run(1'b1, $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
